conf_regs_writer: RTL and testbench

- Initiator end of the configuration simple interface (si_addr/si_data/si_rdy/si_ack).
- Assembles register writes from an incoming byte stream (host link receiver side): address bytes, then data bytes, MSB first.
- Presents each write on the shared bus to the fully associative configuration registers and waits for the asynchronous acknowledge or a timeout.

---
 rtl/conf_regs_writer_if.sv | 35 +++
 rtl/conf_regs_writer.sv | 159 +++++++++++++++
 tb/tb_conf_regs_writer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conf_regs_writer_if.sv
// Configuration simple interface: one write initiator drives address, data and
// request; the register file answers with a combined acknowledge.

`ifndef __REG_ADDR_WIDTH
`define __REG_ADDR_WIDTH 8
`endif
`ifndef __REG_DATA_WIDTH
`define __REG_DATA_WIDTH 16
`endif

interface conf_regs_writer_if #(
    parameter int unsigned REG_ADDR_WIDTH = `__REG_ADDR_WIDTH,
    parameter int unsigned REG_DATA_WIDTH = `__REG_DATA_WIDTH
);
    logic [REG_ADDR_WIDTH-1:0] si_addr;
    logic [REG_DATA_WIDTH-1:0] si_data;
    logic                      si_rdy;
    logic                      si_ack;

    // Writer side: presents the write, observes the acknowledge.
    modport master (
        output si_addr,
        output si_data,
        output si_rdy,
        input  si_ack
    );

    // Register side: observes the write, returns the acknowledge.
    modport slave (
        input  si_addr,
        input  si_data,
        input  si_rdy,
        output si_ack
    );
endinterface

// File: rtl/conf_regs_writer.sv
// Configuration register writer: collects address and data bytes (MSB first)
// from the host byte stream, then issues one write on the simple interface and
// waits for the acknowledge or a timeout.

`ifndef __REG_ADDR_WIDTH
`define __REG_ADDR_WIDTH 8
`endif
`ifndef __REG_DATA_WIDTH
`define __REG_DATA_WIDTH 16
`endif

module conf_regs_writer #(
    parameter int unsigned REG_ADDR_WIDTH = `__REG_ADDR_WIDTH,
    parameter int unsigned REG_DATA_WIDTH = `__REG_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_rdy,
    output logic                rx_ack,
    conf_regs_writer_if.master  si,
    output logic                wr_done,
    output logic                wr_nack
);

    localparam int unsigned AB = REG_ADDR_WIDTH / 8;
    localparam int unsigned DB = REG_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        RX_ADDR = 2'd0,
        RX_DATA = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [2:0]                r_byte_cnt;
    logic [2:0]                w_byte_cnt_nxt;
    logic [7:0]                r_tmo_cnt;
    logic [7:0]                w_tmo_cnt_nxt;
    logic [REG_ADDR_WIDTH-1:0] r_si_addr;
    logic [REG_ADDR_WIDTH-1:0] w_si_addr_nxt;
    logic [REG_DATA_WIDTH-1:0] r_si_data;
    logic [REG_DATA_WIDTH-1:0] w_si_data_nxt;
    logic                      r_si_rdy;
    logic                      w_si_rdy_nxt;
    logic                      r_wr_done;
    logic                      w_wr_done_nxt;
    logic                      r_wr_nack;
    logic                      w_wr_nack_nxt;
    logic                      w_rx_ack;
    logic                      w_rx_take;
    logic                      w_last_addr;
    logic                      w_last_data;
    logic                      w_tmo_last;

    // Byte stream is accepted whenever no write is outstanding.
    assign w_rx_ack    = (r_state != WRITE);
    assign w_rx_take   = rx_rdy & w_rx_ack;
    assign w_last_addr = (r_byte_cnt == 3'(AB - 1));
    assign w_last_data = (r_byte_cnt == 3'(DB - 1));
    assign w_tmo_last  = (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Next-state and next-value logic; every register holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_si_addr_nxt  = r_si_addr;
        w_si_data_nxt  = r_si_data;
        w_si_rdy_nxt   = r_si_rdy;
        w_wr_done_nxt  = 1'b0;
        w_wr_nack_nxt  = 1'b0;

        unique case (r_state)
            RX_ADDR: begin
                if (w_rx_take) begin
                    // Shift-in form also covers the single-byte field:
                    // the shifted-out part is simply truncated away.
                    w_si_addr_nxt = (r_si_addr << 8) | REG_ADDR_WIDTH'(rx_data);
                    if (w_last_addr) begin
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = RX_DATA;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                    end
                end
            end

            RX_DATA: begin
                if (w_rx_take) begin
                    w_si_data_nxt = (r_si_data << 8) | REG_DATA_WIDTH'(rx_data);
                    if (w_last_data) begin
                        w_byte_cnt_nxt = '0;
                        w_tmo_cnt_nxt  = '0;
                        w_si_rdy_nxt   = 1'b1;
                        w_state_nxt    = WRITE;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 3'd1;
                    end
                end
            end

            WRITE: begin
                // Acknowledge takes priority over an expiring timeout.
                if (si.si_ack) begin
                    w_si_rdy_nxt  = 1'b0;
                    w_wr_done_nxt = 1'b1;
                    w_state_nxt   = RX_ADDR;
                end else if (w_tmo_last) begin
                    w_si_rdy_nxt  = 1'b0;
                    w_wr_nack_nxt = 1'b1;
                    w_state_nxt   = RX_ADDR;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt    = RX_ADDR;
                w_byte_cnt_nxt = '0;
                w_tmo_cnt_nxt  = '0;
                w_si_rdy_nxt   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RX_ADDR;
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_si_addr  <= '0;
            r_si_data  <= '0;
            r_si_rdy   <= 1'b0;
            r_wr_done  <= 1'b0;
            r_wr_nack  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_si_addr  <= w_si_addr_nxt;
            r_si_data  <= w_si_data_nxt;
            r_si_rdy   <= w_si_rdy_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_wr_nack  <= w_wr_nack_nxt;
        end
    end

    assign rx_ack     = w_rx_ack;
    assign si.si_addr = r_si_addr;
    assign si.si_data = r_si_data;
    assign si.si_rdy  = r_si_rdy;
    assign wr_done    = r_wr_done;
    assign wr_nack    = r_wr_nack;

endmodule

// File: tb/tb_conf_regs_writer.sv
// Bench for conf_regs_writer: table of frames plus hand-written reset cases,
// responders at 0x0A and 0x0B, and a scoreboard of expected bus writes.

module tb_conf_regs_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_ack;
    logic       wr_done;
    logic       wr_nack;

    always #5 clk = ~clk;

    conf_regs_writer_if #(.REG_ADDR_WIDTH(8), .REG_DATA_WIDTH(16)) bus ();

    conf_regs_writer #(
        .REG_ADDR_WIDTH(8),
        .REG_DATA_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .rx_ack  (rx_ack),
        .si      (bus),
        .wr_done (wr_done),
        .wr_nack (wr_nack)
    );

    // Responder registers at 0x0A and 0x0B.
    logic [15:0] reg0a = 16'h0000;
    logic [15:0] reg0b = 16'h0000;
    assign bus.si_ack = bus.si_rdy & ((bus.si_addr == 8'h0A) | (bus.si_addr == 8'h0B));

    always @(posedge clk) begin
        if (bus.si_rdy && bus.si_addr == 8'h0A) reg0a <= bus.si_data;
        if (bus.si_rdy && bus.si_addr == 8'h0B) reg0b <= bus.si_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = acknowledged, 1 = timed out, 2 = cut short by reset
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          kind;
        int          len;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   exp_done_cnt = 0;
    int   exp_nack_cnt = 0;
    int   seen_done = 0;
    int   seen_nack = 0;
    bit   mon_en = 0;

    logic        prev_rdy = 1'b0;
    int          hi_len = 0;
    logic [7:0]  cap_a;
    logic [15:0] cap_d;
    logic        stable;

    // Bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rx_ack_low_only_in_write", rx_ack, !bus.si_rdy);
            chk("done_nack_exclusive", wr_done & wr_nack, 0);
            if (wr_done) seen_done++;
            if (wr_nack) seen_nack++;
            if (bus.si_rdy) begin
                if (!prev_rdy) begin
                    cap_a  = bus.si_addr;
                    cap_d  = bus.si_data;
                    hi_len = 0;
                    stable = 1'b1;
                end else if (bus.si_addr !== cap_a || bus.si_data !== cap_d) begin
                    stable = 1'b0;
                end
                hi_len++;
            end else if (prev_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", cap_a, cap_d);
                end else begin
                    e = sb.pop_front();
                    chk("write_addr", cap_a, e.addr);
                    chk("write_data", cap_d, e.data);
                    chk("si_rdy_width", hi_len, e.len);
                    chk("bus_stable", stable, 1);
                    chk("wr_done_pulse", wr_done, e.kind == 0);
                    chk("wr_nack_pulse", wr_nack, e.kind == 1);
                end
            end
            prev_rdy = bus.si_rdy;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            rx_rdy  = 1'b0;
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_rdy  = 1'b1;
        rx_data = b;
        n = 0;
        while (!rx_ack && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rx_ack) begin
            checks++;
            errors++;
            $display("FAIL rx_ack_wait: got 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input int gapmax);
        send_byte(a, $urandom_range(0, gapmax));
        send_byte(d[15:8], $urandom_range(0, gapmax));
        send_byte(d[7:0], $urandom_range(0, gapmax));
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [15:0] d, input int kind, input int len);
        exp_t x;
        x.addr = a;
        x.data = d;
        x.kind = kind;
        x.len  = len;
        sb.push_back(x);
        if (kind == 0) exp_done_cnt++;
        if (kind == 1) exp_nack_cnt++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_si_addr"}, bus.si_addr, 0);
        chk({tag, "_si_data"}, bus.si_data, 0);
        chk({tag, "_si_rdy"}, bus.si_rdy, 0);
        chk({tag, "_wr_done"}, wr_done, 0);
        chk({tag, "_wr_nack"}, wr_nack, 0);
        chk({tag, "_rx_ack"}, rx_ack, 1);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          gapmax;
        int          kind;
        int          len;
        logic [15:0] reg_a;
        logic [15:0] reg_b;
        bit          wait_after;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h0A, 16'h1234, 0, 0, 1,  16'h1234, 16'h0000, 1'b1};
        vecs[1] = '{8'h05, 16'hABCD, 0, 1, 16, 16'h1234, 16'h0000, 1'b1};
        vecs[2] = '{8'h0A, 16'h0001, 0, 0, 1,  16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{8'h0B, 16'hFFFF, 0, 0, 1,  16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{8'h0A, 16'hBEEF, 0, 0, 1,  16'hBEEF, 16'hFFFF, 1'b1};
        vecs[5] = '{8'h0A, 16'h1234, 5, 0, 1,  16'h1234, 16'hFFFF, 1'b1};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            expect_write(vecs[i].addr, vecs[i].data, vecs[i].kind, vecs[i].len);
            send_frame(vecs[i].addr, vecs[i].data, vecs[i].gapmax);
            if (vecs[i].wait_after) begin
                drain();
                chk($sformatf("vec%0d_reg0a", i), reg0a, vecs[i].reg_a);
                chk($sformatf("vec%0d_reg0b", i), reg0b, vecs[i].reg_b);
            end
        end

        // Reset in the middle of a frame discards the partial frame.
        send_byte(8'h0A, 0);
        send_byte(8'h12, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midframe_reset");
        rst = 1'b1;
        expect_write(8'h0B, 16'h5678, 0, 1);
        send_frame(8'h0B, 16'h5678, 0);
        drain();
        chk("midframe_reg0b", reg0b, 16'h5678);
        chk("midframe_reg0a_untouched", reg0a, 16'h1234);

        // Reset during an unanswered write: request drops, no nack pulse.
        expect_write(8'h05, 16'hABCD, 2, 5);
        send_frame(8'h05, 16'hABCD, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_si_rdy", bus.si_rdy, 0);
        chk("abort_wr_nack", wr_nack, 0);
        rst = 1'b1;
        drain();
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        expect_write(8'h0A, 16'hCAFE, 0, 1);
        send_frame(8'h0A, 16'hCAFE, 2);
        drain();
        chk("after_abort_reg0a", reg0a, 16'hCAFE);

        chk("wr_done_count", seen_done, exp_done_cnt);
        chk("wr_nack_count", seen_nack, exp_nack_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
